rvv_cmd_queue: RTL and testbench

Circular command queue between the RVV front end and the vector backend. It accepts up to N aligned RVVCmd entries per cycle, which arrive without per-entry handshake, and advertises its free space so the front end never overruns it. It presents up to M in-order commands per cycle to the backend under a valid/ready handshake. A flush discards all queued commands when the front end traps.

---
 rtl/rvv_cmd_queue_pkg.sv | 29 ++
 rtl/rvv_cmd_queue.sv | 112 +++++++++++
 tb/tb_rvv_cmd_queue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rvv_cmd_queue_pkg.sv
// Shared RVV types and default sizing for the command queue.
`default_nettype none

package rvv_cmd_queue_pkg;

  localparam int RVV_CMDQ_ENQ   = 4;
  localparam int RVV_CMDQ_DEQ   = 2;
  localparam int RVV_CMDQ_DEPTH = 16;

  typedef struct packed {
    logic [5:0] funct6;
    logic       vm;
    logic [4:0] vs2;
    logic [4:0] vs1;
    logic [2:0] funct3;
    logic [4:0] vd;
    logic [6:0] opcode;
  } RVVInstruction;

  typedef struct packed {
    RVVInstruction insn;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic [7:0]    vl;
  } RVVCmd;

endpackage

`default_nettype wire

// File: rtl/rvv_cmd_queue.sv
// Circular RVV command queue: N-wide unhandshaked enqueue, M-wide in-order
// valid/ready dequeue, flush, and clamped free-space advertisement.
`default_nettype none

module rvv_cmd_queue
  import rvv_cmd_queue_pkg::*;
#(
  parameter int N            = RVV_CMDQ_ENQ,
  parameter int M            = RVV_CMDQ_DEQ,
  parameter int DEPTH        = RVV_CMDQ_DEPTH,
  parameter int CAPACITYBITS = $clog2(2*N+1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N-1:0]            enq_valid_i,
  input  RVVCmd [N-1:0]           enq_data_i,
  output logic [CAPACITYBITS-1:0] capacity_o,
  output logic [M-1:0]            deq_valid_o,
  output RVVCmd [M-1:0]           deq_data_o,
  input  logic [M-1:0]            deq_ready_i,
  input  logic                    flush_i,
  output logic                    empty_o,
  output logic                    overflow_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [PTRW-1:0] head;
  logic [PTRW-1:0] tail;
  logic [CNTW-1:0] count;
  RVVCmd           mem [DEPTH];

  logic [CNTW-1:0] free_cnt;
  logic [CNTW-1:0] enq_n;
  logic [CNTW-1:0] enq_acc;
  logic [CNTW-1:0] deq_n;
  logic [CNTW-1:0] rank [N];

  assign free_cnt   = CNTW'(DEPTH) - count;
  assign enq_acc    = (enq_n > free_cnt) ? free_cnt : enq_n;
  assign empty_o    = (count == '0);
  assign capacity_o = (free_cnt > CNTW'(2*N)) ? CAPACITYBITS'(2*N) : CAPACITYBITS'(free_cnt);

  // rank[i] is the packed slot of lane i among the set lanes; the final sum is the popcount
  always_comb begin : p_enq_rank
    logic [CNTW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      rank[i] = acc;
      acc     = acc + CNTW'(enq_valid_i[i]);
    end
    enq_n = acc;
  end

  always_comb begin : p_deq_view
    for (int j = 0; j < M; j++) begin
      deq_valid_o[j] = (CNTW'(j) < count);
      deq_data_o[j]  = mem[head + PTRW'(j)];
    end
  end

  // Retire only the unbroken run of accepted lanes starting at lane 0
  always_comb begin : p_deq_count
    logic stop;
    stop  = 1'b0;
    deq_n = '0;
    for (int j = 0; j < M; j++) begin
      if (!stop && deq_valid_o[j] && deq_ready_i[j]) begin
        deq_n = deq_n + CNTW'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PTRW'(enq_acc);
      head  <= head + PTRW'(deq_n);
      count <= count + enq_acc - deq_n;
      if (enq_n > free_cnt) begin
        overflow_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int i = 0; i < N; i++) begin
        if (enq_valid_i[i] && (rank[i] < enq_acc)) begin
          mem[tail + PTRW'(rank[i])] <= enq_data_i[i];
        end
      end
    end
  end

  a_enq_prefix : assert property (@(posedge clk) disable iff (!rstn)
    ((enq_valid_i & (enq_valid_i + N'(1))) == '0));

endmodule

`default_nettype wire

// File: tb/tb_rvv_cmd_queue.sv
// Self-checking bench for rvv_cmd_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
`default_nettype none

module tb_rvv_cmd_queue;
  import rvv_cmd_queue_pkg::*;

  localparam int N     = 4;
  localparam int M     = 2;
  localparam int DEPTH = 16;
  localparam int CB    = $clog2(2*N+1);

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [N-1:0]      enq_valid = '0;
  RVVCmd [N-1:0]     enq_data = '0;
  logic [CB-1:0]     capacity;
  logic [M-1:0]      deq_valid;
  RVVCmd [M-1:0]     deq_data;
  logic [M-1:0]      deq_ready = '0;
  logic              flush = 1'b0;
  logic              empty;
  logic              overflow;

  rvv_cmd_queue #(.N(N), .M(M), .DEPTH(DEPTH), .CAPACITYBITS(CB)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enq_valid_i (enq_valid),
    .enq_data_i  (enq_data),
    .capacity_o  (capacity),
    .deq_valid_o (deq_valid),
    .deq_data_o  (deq_data),
    .deq_ready_i (deq_ready),
    .flush_i     (flush),
    .empty_o     (empty),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    seq   = 0;
  RVVCmd mq[$];
  bit    movf  = 1'b0;

  typedef struct {
    logic [N-1:0] ev;
    logic [M-1:0] rdy;
    logic         fl;
    int           cap;
    logic         emp;
    logic [M-1:0] dv;
    logic         ovf;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called one unit after a rising edge; leaves time mid-cycle with outputs settled.
  task automatic drive(input logic [N-1:0] ev, input logic [M-1:0] rdy, input logic fl);
    RVVCmd d;
    for (int i = 0; i < N; i++) begin
      d.insn = RVVInstruction'($urandom);
      d.rs1  = 32'(seq);
      d.rs2  = $urandom;
      d.vl   = 8'($urandom);
      seq++;
      enq_data[i] = d;
    end
    enq_valid = ev;
    deq_ready = rdy;
    flush     = fl;
    #2;
  endtask

  task automatic check_model();
    int sz;
    int fr;
    sz = mq.size();
    fr = DEPTH - sz;
    chk("capacity", 128'(capacity), 128'((fr > 2*N) ? 2*N : fr));
    chk("empty", 128'(empty), 128'(sz == 0));
    chk("overflow", 128'(overflow), 128'(movf));
    for (int j = 0; j < M; j++) begin
      chk("deq_valid", 128'(deq_valid[j]), 128'(j < sz));
      if (j < sz) chk("deq_data", 128'(deq_data[j]), 128'(mq[j]));
    end
  endtask

  // Queue semantics straight from the rules, then take the clock edge.
  task automatic advance();
    int sz0, fr0, en, acc, dn, k;
    sz0 = mq.size();
    fr0 = DEPTH - sz0;
    en  = $countones(enq_valid);
    acc = (en < fr0) ? en : fr0;
    if (flush) begin
      mq.delete();
    end else begin
      dn = 0;
      for (int j = 0; j < M; j++) begin
        if (j < sz0 && deq_ready[j]) dn++;
        else break;
      end
      repeat (dn) void'(mq.pop_front());
      k = 0;
      for (int i = 0; i < N; i++) begin
        if (enq_valid[i]) begin
          if (k < acc) mq.push_back(enq_data[i]);
          k++;
        end
      end
      if (en > fr0) movf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [N-1:0] ev, input logic [M-1:0] rdy, input logic fl);
    drive(ev, rdy, fl);
    check_model();
    advance();
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 2'b00, 1'b0, 8, 1'b1, 2'b00, 1'b0};
    tbl[1]  = '{4'b1111, 2'b00, 1'b0, 8, 1'b0, 2'b11, 1'b0};
    tbl[2]  = '{4'b1111, 2'b00, 1'b0, 8, 1'b0, 2'b11, 1'b0};
    tbl[3]  = '{4'b1111, 2'b00, 1'b0, 4, 1'b0, 2'b11, 1'b0};
    tbl[4]  = '{4'b0000, 2'b00, 1'b0, 0, 1'b0, 2'b11, 1'b0};
    tbl[5]  = '{4'b0000, 2'b11, 1'b0, 0, 1'b0, 2'b11, 1'b0};
    tbl[6]  = '{4'b1111, 2'b00, 1'b0, 2, 1'b0, 2'b11, 1'b0};
    tbl[7]  = '{4'b0000, 2'b00, 1'b0, 0, 1'b0, 2'b11, 1'b1};
    tbl[8]  = '{4'b0000, 2'b11, 1'b0, 0, 1'b0, 2'b11, 1'b1};
    tbl[9]  = '{4'b0000, 2'b11, 1'b0, 2, 1'b0, 2'b11, 1'b1};
    tbl[10] = '{4'b0000, 2'b11, 1'b0, 4, 1'b0, 2'b11, 1'b1};
    tbl[11] = '{4'b0001, 2'b11, 1'b0, 6, 1'b0, 2'b11, 1'b1};
    tbl[12] = '{4'b0000, 2'b00, 1'b1, 7, 1'b0, 2'b11, 1'b1};
    tbl[13] = '{4'b0011, 2'b00, 1'b0, 8, 1'b1, 2'b00, 1'b1};
    tbl[14] = '{4'b0000, 2'b10, 1'b0, 8, 1'b0, 2'b11, 1'b1};
    tbl[15] = '{4'b0000, 2'b01, 1'b0, 8, 1'b0, 2'b11, 1'b1};
    tbl[16] = '{4'b0000, 2'b11, 1'b0, 8, 1'b0, 2'b01, 1'b1};
    tbl[17] = '{4'b0000, 2'b11, 1'b0, 8, 1'b1, 2'b00, 1'b1};
    tbl[18] = '{4'b0000, 2'b00, 1'b0, 8, 1'b1, 2'b00, 1'b1};

    // Reset
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_capacity", 128'(capacity), 128'(8));
    chk("reset_empty", 128'(empty), 128'(1));
    chk("reset_deq_valid", 128'(deq_valid), 128'(0));
    chk("reset_overflow", 128'(overflow), 128'(0));

    // Directed table: fill, full, overflow, flush, partial ready, empty ready
    for (int t = 0; t < 19; t++) begin
      drive(tbl[t].ev, tbl[t].rdy, tbl[t].fl);
      chk($sformatf("tbl%0d_capacity", t), 128'(capacity), 128'(tbl[t].cap));
      chk($sformatf("tbl%0d_empty", t), 128'(empty), 128'(tbl[t].emp));
      chk($sformatf("tbl%0d_deq_valid", t), 128'(deq_valid), 128'(tbl[t].dv));
      chk($sformatf("tbl%0d_overflow", t), 128'(overflow), 128'(tbl[t].ovf));
      check_model();
      advance();
    end

    // Partial ready with capacity visibly below the clamp: 11 queued
    cycle(4'b1111, 2'b00, 1'b0);
    cycle(4'b1111, 2'b00, 1'b0);
    cycle(4'b0111, 2'b00, 1'b0);
    cycle(4'b0000, 2'b10, 1'b0);
    drive(4'b0000, 2'b01, 1'b0);
    chk("pr_capacity_before", 128'(capacity), 128'(5));
    check_model();
    advance();
    drive(4'b0000, 2'b00, 1'b0);
    chk("pr_capacity_after", 128'(capacity), 128'(6));
    check_model();
    advance();

    // Flush colliding with a 4-wide enqueue and 2-wide dequeue
    cycle(4'b1111, 2'b11, 1'b1);
    drive(4'b0000, 2'b00, 1'b0);
    chk("flush_empty", 128'(empty), 128'(1));
    chk("flush_capacity", 128'(capacity), 128'(8));
    chk("flush_deq_valid", 128'(deq_valid), 128'(0));
    chk("flush_overflow_sticky", 128'(overflow), 128'(1));
    advance();

    // Asynchronous reset in the middle of a cycle
    cycle(4'b0111, 2'b00, 1'b0);
    drive(4'b0000, 2'b00, 1'b0);
    rstn = 1'b0;
    #1;
    chk("async_rst_empty", 128'(empty), 128'(1));
    chk("async_rst_capacity", 128'(capacity), 128'(8));
    chk("async_rst_deq_valid", 128'(deq_valid), 128'(0));
    chk("async_rst_overflow", 128'(overflow), 128'(0));
    mq.delete();
    movf = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Wrap-around stream: 40 commands, bursts of 3 on alternate cycles
    begin
      int sent;
      sent = 0;
      while (sent < 40) begin
        int k;
        k = (40 - sent < 3) ? 40 - sent : 3;
        cycle(N'((1 << k) - 1), 2'b11, 1'b0);
        sent += k;
        cycle(4'b0000, 2'b11, 1'b0);
      end
      for (int d = 0; d < 20 && mq.size() != 0; d++) cycle(4'b0000, 2'b11, 1'b0);
      drive(4'b0000, 2'b00, 1'b0);
      chk("wrap_no_overflow", 128'(overflow), 128'(0));
      chk("wrap_drained", 128'(empty), 128'(1));
      advance();
    end

    // Randomized prefix-shaped traffic
    for (int r = 0; r < 400; r++) begin
      int k;
      k = $urandom_range(0, N);
      cycle(N'((1 << k) - 1), M'($urandom), ($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
